// File: rtl/cu_multicycle.sv
// Multicycle control unit: takes one instruction per valid/ready handshake and steps it
// through DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK, driving ALU and memory controls.
module cu_multicycle #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4,
    parameter int ZERO_REG   = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int REG_BITS    = $clog2(REG_COUNT),
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + DATA_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [DATA_WIDTH-1:0]  result2,
    output logic [DATA_WIDTH-1:0]  operand1,
    output logic [DATA_WIDTH-1:0]  operand2,
    output logic [DATA_WIDTH-1:0]  offset,
    output logic [3:0]             opcode,
    output logic                   sel1,
    output logic                   sel3,
    output logic                   w_r,
    output logic                   retire,
    output logic [CNT_WIDTH-1:0]   retired_cnt,
    input  logic [REG_BITS-1:0]    dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
);
    // state      | meaning
    // S_IDLE     | ready for the next instruction
    // S_DECODE   | instruction latched, registers read on exit
    // S_EXECUTE  | ALU operation in progress
    // S_MEM      | data memory access (loadR / storeR)
    // S_WB       | result2 written to rd on exit
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    localparam int OFF_LSB = 4;
    localparam int RS2_LSB = OFF_LSB + DATA_WIDTH;
    localparam int RS1_LSB = RS2_LSB + REG_BITS;
    localparam int RD_LSB  = RS1_LSB + REG_BITS;
    localparam int CLS_LSB = RD_LSB + REG_BITS;

    localparam logic [1:0] CLS_NOP   = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    state_t                  state_q, state_d;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [DATA_WIDTH-1:0]   regfile_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   operand1_q, operand2_q, offset_q;
    logic [3:0]              opcode_q;
    logic                    sel1_q, sel3_q, retire_q, retire_d;
    logic [CNT_WIDTH-1:0]    cnt_q;

    logic [1:0]              cls_q, cls_in;
    logic [REG_BITS-1:0]     rd_q, rs1_q, rs2_q, op2_idx;
    logic [DATA_WIDTH-1:0]   rs1_val, op2_val;
    logic                    accept, done, wb_en;

    assign cls_in  = instr[CLS_LSB +: 2];
    assign cls_q   = instr_q[CLS_LSB +: 2];
    assign rd_q    = instr_q[RD_LSB +: REG_BITS];
    assign rs1_q   = instr_q[RS1_LSB +: REG_BITS];
    assign rs2_q   = instr_q[RS2_LSB +: REG_BITS];
    assign op2_idx = (cls_q == CLS_STD) ? rs2_q : rd_q;

    // Register 0 is forced to zero on every read path when ZERO_REG is set.
    assign rs1_val  = (ZERO_REG != 0 && rs1_q == '0)    ? '0 : regfile_q[rs1_q];
    assign op2_val  = (ZERO_REG != 0 && op2_idx == '0)  ? '0 : regfile_q[op2_idx];
    assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : regfile_q[dbg_addr];

    assign accept   = (state_q == S_IDLE) && instr_valid;
    assign done     = (state_q == S_WB) || (state_q == S_MEM && cls_q == CLS_STORE);
    assign retire_d = (accept && cls_in == CLS_NOP) || done;
    assign wb_en    = (state_q == S_WB) && !(ZERO_REG != 0 && rd_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = (accept && cls_in != CLS_NOP) ? S_DECODE : S_IDLE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = (cls_q == CLS_STD) ? S_WB : S_MEM;
            S_MEM:     state_d = (cls_q == CLS_LOAD) ? S_WB : S_IDLE;
            S_WB:      state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        w_r         = (cls_q == CLS_STORE) && (state_q == S_EXECUTE || state_q == S_MEM);
        operand1    = operand1_q;
        operand2    = operand2_q;
        offset      = offset_q;
        opcode      = opcode_q;
        sel1        = sel1_q;
        sel3        = sel3_q;
        retire      = retire_q;
        retired_cnt = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            offset_q   <= '0;
            opcode_q   <= 4'b1111;
            sel1_q     <= 1'b0;
            sel3_q     <= 1'b0;
            retire_q   <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < REG_COUNT; i++) regfile_q[i] <= DATA_WIDTH'(i);
        end else begin
            if (accept) instr_q <= instr;
            retire_q <= retire_d;
            if (retire_d) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (state_q == S_DECODE) begin
                operand1_q <= rs1_val;
                operand2_q <= op2_val;
                offset_q   <= instr_q[OFF_LSB +: DATA_WIDTH];
                opcode_q   <= instr_q[3:0];
                sel1_q     <= (cls_q != CLS_LOAD);
                sel3_q     <= (cls_q != CLS_STD);
            end else if (state_q != S_IDLE && state_d == S_IDLE) begin
                operand1_q <= '0;
                operand2_q <= '0;
                offset_q   <= '0;
                opcode_q   <= 4'b1111;
                sel1_q     <= 1'b0;
                sel3_q     <= 1'b0;
            end
            if (wb_en) regfile_q[rd_q] <= result2;
        end
    end
endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: two instances (plain, and zero-register with a 2-bit counter)
// share stimulus and are checked every cycle against a timing-table model.
module tb_cu_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [7:0]  result2 = '0;
    logic [1:0]  dbg_addr = '0;

    logic        rdy [2];
    logic [7:0]  op1 [2];
    logic [7:0]  op2 [2];
    logic [7:0]  off [2];
    logic [3:0]  opc [2];
    logic        s1 [2];
    logic        s3 [2];
    logic        wr [2];
    logic        ret [2];
    logic [7:0]  dbg [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cu_multicycle dut0 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy[0]),
        .result2(result2), .operand1(op1[0]), .operand2(op2[0]), .offset(off[0]), .opcode(opc[0]),
        .sel1(s1[0]), .sel3(s3[0]), .w_r(wr[0]), .retire(ret[0]), .retired_cnt(cnt0),
        .dbg_addr(dbg_addr), .dbg_data(dbg[0])
    );

    cu_multicycle #(.ZERO_REG(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy[1]),
        .result2(result2), .operand1(op1[1]), .operand2(op2[1]), .offset(off[1]), .opcode(opc[1]),
        .sel1(s1[1]), .sel3(s3[1]), .w_r(wr[1]), .retire(ret[1]), .retired_cnt(cnt1),
        .dbg_addr(dbg_addr), .dbg_data(dbg[1])
    );

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: an in-flight instruction is tracked by its cycle number after the accept edge.
    bit         busy;
    int         cyc;
    logic [1:0] mcls, mrd, mrs1, mrs2;
    logic [7:0] moff;
    logic [3:0] mop;
    logic [7:0] R [2][4];
    logic [7:0] mo1 [2];
    logic [7:0] mo2 [2];
    bit         mret;
    int         mcnt;

    function automatic logic [7:0] mread(input int d, input logic [1:0] a);
        return (d == 1 && a == 2'd0) ? 8'h00 : R[d][a];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy = 0; cyc = 0; mret = 0; mcnt = 0; mcls = 0;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) R[d][i] = 8'(i);
        end else begin
            mret = 0;
            if (!busy) begin
                if (instr_valid) begin
                    {mcls, mrd, mrs1, mrs2, moff, mop} = instr;
                    if (mcls == 2'd0) begin
                        mret = 1; mcnt++;
                    end else begin
                        busy = 1; cyc = 1;
                    end
                end
            end else begin
                cyc++;
                if (cyc == 2)
                    for (int d = 0; d < 2; d++) begin
                        mo1[d] = mread(d, mrs1);
                        mo2[d] = mread(d, (mcls == 2'd1) ? mrs2 : mrd);
                    end
                if (cyc == ((mcls == 2'd2) ? 5 : 4)) begin
                    if (mcls != 2'd3) begin
                        R[0][mrd] = result2;
                        if (mrd != 2'd0) R[1][mrd] = result2;
                    end
                    busy = 0; mret = 1; mcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit vout;
        vout = busy && cyc >= 2;
        for (int d = 0; d < 2; d++) begin
            check("ready",    d, rdy[d], !busy);
            check("operand1", d, op1[d], vout ? mo1[d] : 8'h00);
            check("operand2", d, op2[d], vout ? mo2[d] : 8'h00);
            check("offset",   d, off[d], vout ? moff : 8'h00);
            check("opcode",   d, opc[d], vout ? mop : 4'hF);
            check("sel1",     d, s1[d],  vout && mcls != 2'd2);
            check("sel3",     d, s3[d],  vout && mcls != 2'd1);
            check("w_r",      d, wr[d],  busy && mcls == 2'd3 && cyc >= 2);
            check("retire",   d, ret[d], mret);
            check("dbg_data", d, dbg[d], mread(d, dbg_addr));
        end
        check("retired_cnt", 0, cnt0, mcnt & 32'hFFFF);
        check("retired_cnt", 1, cnt1, mcnt & 32'h3);
    end

    function automatic logic [19:0] mk(input int c, input int rd, input int r1, input int r2,
                                       input int of, input int op);
        return {c[1:0], rd[1:0], r1[1:0], r2[1:0], of[7:0], op[3:0]};
    endfunction

    task automatic issue(input logic [19:0] in, input logic [7:0] r);
        @(negedge clk); #1;
        instr = in; instr_valid = 1'b1; result2 = r;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = ~in;
    endtask

    // Returns the cycle retire was seen in (0 on timeout), w_r cycle count, and cycle-2 outputs.
    task automatic wait_retire(output int c, output int wrc, output logic [31:0] o1,
                               output logic [31:0] o2, output logic [31:0] a1,
                               output logic [31:0] a3, output logic [31:0] of);
        c = 0; wrc = 0; o1 = 0; o2 = 0; a1 = 0; a3 = 0; of = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (wr[0]) wrc++;
            if (k == 1) begin
                o1 = op1[0]; o2 = op2[0]; a1 = s1[0]; a3 = s3[0]; of = off[0];
            end
            if (ret[0]) begin
                c = k + 1;
                break;
            end
        end
        check("retire_seen", 0, c != 0, 1);
    endtask

    int c, w;
    logic [31:0] o1, o2, a1, a3, of;

    initial begin
        @(negedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a); #1;
            check("rst_dbg", 0, dbg[0], a);
        end
        check("rst_opcode", 0, opc[0], 4'hF);
        check("rst_ready", 0, rdy[0], 1);
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        dbg_addr = 2'd1;
        issue(mk(1, 1, 2, 3, 0, 0), 8'h05);
        wait_retire(c, w, o1, o2, a1, a3, of);
        check("std_latency", 0, c, 4);
        check("std_op1", 0, o1, 2);
        check("std_op2", 0, o2, 3);
        check("std_sel1", 0, a1, 1);
        check("std_sel3", 0, a3, 0);
        check("std_r1", 0, dbg[0], 8'h05);

        dbg_addr = 2'd3;
        issue(mk(2, 3, 1, 0, 8'h10, 2), 8'hAA);
        wait_retire(c, w, o1, o2, a1, a3, of);
        check("load_latency", 0, c, 5);
        check("load_op1", 0, o1, 8'h05);
        check("load_sel1", 0, a1, 0);
        check("load_sel3", 0, a3, 1);
        check("load_offset", 0, of, 8'h10);
        check("load_r3", 0, dbg[0], 8'hAA);

        dbg_addr = 2'd2;
        issue(mk(3, 2, 0, 1, 8'h04, 3), 8'h55);
        wait_retire(c, w, o1, o2, a1, a3, of);
        check("store_latency", 0, c, 4);
        check("store_wr_cycles", 0, w, 2);
        check("store_op2", 0, o2, 2);
        check("store_r2", 0, dbg[0], 8'h02);

        dbg_addr = 2'd1;
        issue(mk(2, 1, 2, 3, 1, 1), 8'h33);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0; #1;
        check("midrst_ready", 0, rdy[0], 1);
        check("midrst_retire", 0, ret[0], 0);
        check("midrst_cnt", 0, cnt0, 0);
        check("midrst_opcode", 0, opc[0], 4'hF);
        check("midrst_r1", 0, dbg[0], 8'h01);
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        dbg_addr = 2'd0;
        @(negedge clk); #1;
        instr = mk(0, 1, 1, 1, 0, 0); instr_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 instr = mk(1, 0, 1, 2, 0, 5); result2 = 8'h7F;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1 instr_valid = 1'b1; instr = mk(0, 2, 2, 2, 0, 0);
        @(posedge clk); #1 instr_valid = 1'b0;
        wait_retire(c, w, o1, o2, a1, a3, of);
        check("burst_cnt", 0, cnt0, 5);
        check("burst_cnt", 1, cnt1, 1);
        check("zero_reg_r0", 1, dbg[1], 8'h00);
        check("plain_r0", 0, dbg[0], 8'h7F);

        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1;
        instr = mk(0, 0, 0, 0, 0, 0); instr_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt", 1, cnt1, 1);
        check("nowrap_cnt", 0, cnt0, 5);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
